icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Instruction-side memory responder. Answers the fetch unit's imem request interface (imem_addr, imem_rmask -> imem_resp, imem_rdata).
- Direct-mapped, read-only cache built from flop arrays, with 32-byte lines.
- Misses are refilled from the burst memory over a 4-beat x 64-bit read interface.
- Sits between the fetch unit and the burst memory port.

Parameters:
- SETS, 16, number of lines; power of two, minimum 2.
- INIT_PC, 32'h60000000, documentation only; no reset-time prefetch.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst=0 resets)
- imem_addr  in  32  fetch address; bits [1:0] ignored
- imem_rmask  in  4  4'b1111 = request, 4'b0000 = none; other values treated as 4'b1111
- imem_resp  out  1  one-cycle pulse: imem_rdata valid
- imem_rdata  out  32  instruction word
- bmem_addr  out  32  line-aligned refill address
- bmem_read  out  1  one-cycle refill request pulse
- bmem_ready  in  1  memory can accept bmem_read
- bmem_rvalid  in  1  refill beat valid
- bmem_rdata  in  64  refill beat; beat k = line bytes [8k+7:8k]

Behaviour:
- Address split:
  - offset = addr[4:0]; word select = addr[4:2]
  - index = addr[5+log2(SETS)-1:5]
  - tag = remaining upper bits
- Reset (rst=0 at posedge):
  - all valid bits = 0; state = IDLE; beat counter = 0
  - imem_resp = 0, imem_rdata = 0, bmem_read = 0, bmem_addr = 0
  - tag/data arrays need no reset
- Acceptance: a request is captured (addr -> req_addr) at a posedge only when imem_rmask != 0 and either state == IDLE or imem_resp is high that cycle. Otherwise the request is not sampled; fetch holds its address until it sees a response.
- States:
  - IDLE: on capture -> COMPARE.
  - COMPARE:
    - Hit: imem_resp=1, imem_rdata = selected word. Next state is COMPARE if a new request is captured this cycle, else IDLE.
    - Miss: -> FILL_REQ, imem_resp=0.
  - FILL_REQ: bmem_addr = {req_addr[31:5], 5'b0}; bmem_read=1 only while bmem_ready=1. Move to FILL_WAIT the cycle bmem_read is issued.
  - FILL_WAIT: each bmem_rvalid stores bmem_rdata into fill buffer slot beat_cnt, then beat_cnt++. On the 4th beat, write the line, tag and valid=1 into the array and go to RESPOND.
  - RESPOND: imem_resp=1, imem_rdata = requested word from the fill buffer. Capture rule as in COMPARE; next state COMPARE or IDLE.
- Latency:
  - hit: resp exactly 1 cycle after capture; back-to-back hits give 1 resp/cycle
  - miss: bmem_read issued 1 cycle after the miss-detect cycle (if ready); resp 1 cycle after the 4th beat
- An accepted request always completes with exactly one imem_resp, even if imem_rmask drops to 0 (fetch flush) while it is outstanding. Fetch relies on this resp to redirect.
- imem_rdata holds its last value when imem_resp=0.
- bmem_rvalid is ignored outside FILL_WAIT. Stray beats after a reset are dropped.
- Reset mid-fill: the fill is abandoned, the line is not written, and no resp is generated.
- No writes or invalidation from the core; self-modifying code is unsupported.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined:
  - adds outputs hit_count[31:0] and miss_count[31:0], reset to 0
  - hit_count +1 on each COMPARE hit; miss_count +1 on each COMPARE miss
  - both counters saturate at 32'hFFFFFFFF
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package rv32i_types gains:
  - ICACHE_LINE_BYTES=32, ICACHE_BEATS=4
  - icache_state_t enum {IDLE, COMPARE, FILL_REQ, FILL_WAIT, RESPOND}
- One sub-module icache_line_array: SETS-deep tag/valid/256-bit data flop array.
  - combinational read by index
  - one synchronous write port
  - valid cleared by rst

Test Plan:
- Cold miss: request 0x60000000 -> bmem_read pulse with bmem_addr=0x60000000; beats 64'h11..,22..,33..,44.. -> imem_resp one cycle after beat 4, rdata = beat0[31:0].
- Sequential hits: after fill, 0x60000004..0x6000001C presented on each resp -> 7 consecutive resp cycles; 0x6000000C returns beat1[63:32].
- Conflict (SETS=16): 0x60000000, then 0x60000200 (same index 0, different tag) -> second refill. Then 0x60000000 -> third refill, miss_count=3.
- Flush mid-fill: imem_rmask=0 from the cycle after capture through beat 2 -> exactly one resp; no new capture while rmask=0.
- Reset mid-fill: rst=0 during beat 2, then 2 extra rvalid beats -> outputs zero, beats ignored; a following request to the same line misses.
- bmem_ready held 0 for 5 cycles in FILL_REQ -> bmem_read stays low; it pulses once, on the first ready cycle.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types: instruction-cache geometry, controller states and the
// line word-select helper used by icache_responder.
package rv32i_types;

    localparam int ICACHE_LINE_BYTES = 32;
    localparam int ICACHE_BEATS      = 4;
    localparam int ICACHE_LINE_BITS  = ICACHE_LINE_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        FILL_REQ  = 3'd2,
        FILL_WAIT = 3'd3,
        RESPOND   = 3'd4
    } icache_state_t;

    // Pick 32-bit word wsel out of a 256-bit line (word 0 in the low bits).
    function automatic logic [31:0] icache_word(input logic [ICACHE_LINE_BITS-1:0] line,
                                                input logic [2:0]                  wsel);
        return line[{wsel, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Tag / valid / line storage for the direct-mapped instruction cache.
// Combinational read by index, one synchronous write port; only the valid
// bits are reset, tag and data contents are don't-care until written.
module icache_line_array
    import rv32i_types::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 27 - IDX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IDX_W-1:0]            rd_index,
    output logic                        rd_valid,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [ICACHE_LINE_BITS-1:0] rd_line,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_index,
    input  logic [TAG_W-1:0]            wr_tag,
    input  logic [ICACHE_LINE_BITS-1:0] wr_line
);

    logic [SETS-1:0]             valid_r;
    logic [TAG_W-1:0]            tag_r  [SETS];
    logic [ICACHE_LINE_BITS-1:0] data_r [SETS];

    // Valid bits: cleared by reset, set when a refilled line is installed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    // Tag and line data: plain write-enabled storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_index]  <= wr_tag;
            data_r[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_line  = data_r[rd_index];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache between the fetch unit (imem_*)
// and the 4 x 64-bit burst memory (bmem_*). Hits answer in the COMPARE cycle
// so back-to-back hits stream one word per cycle; misses refill a full line.
// Optional build macro ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_responder
    import rv32i_types::*;
#(
    parameter int          SETS    = 16,
    parameter logic [31:0] INIT_PC = 32'h6000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic        imem_resp,
    output logic [31:0] imem_rdata,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    input  logic        bmem_ready,
    input  logic        bmem_rvalid,
    input  logic [63:0] bmem_rdata
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 5 - IDX_W;

    icache_state_t               state_r;
    logic [31:0]                 req_addr_r;
    logic [1:0]                  beat_cnt_r;
    logic [63:0]                 fill_buf_r [ICACHE_BEATS];
    logic [31:0]                 bmem_addr_r;
    logic [31:0]                 rdata_r;

    logic [IDX_W-1:0]            req_index_s;
    logic [TAG_W-1:0]            req_tag_s;
    logic                        rd_valid_s;
    logic [TAG_W-1:0]            rd_tag_s;
    logic [ICACHE_LINE_BITS-1:0] rd_line_s;
    logic [ICACHE_LINE_BITS-1:0] fill_line_s;
    logic [ICACHE_LINE_BITS-1:0] wr_line_s;
    logic                        hit_s;
    logic                        resp_s;
    logic [31:0]                 resp_word_s;
    logic                        capture_s;
    logic                        last_beat_s;
    logic                        wr_en_s;
    logic                        unused_s;

    icache_line_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_line_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_line  (rd_line_s),
        .wr_en    (wr_en_s),
        .wr_index (req_index_s),
        .wr_tag   (req_tag_s),
        .wr_line  (wr_line_s)
    );

    // Lookup, response word selection, acceptance and refill-install decode.
    always_comb begin
        req_index_s = req_addr_r[5 +: IDX_W];
        req_tag_s   = req_addr_r[31 -: TAG_W];
        fill_line_s = {fill_buf_r[3], fill_buf_r[2], fill_buf_r[1], fill_buf_r[0]};
        // The last beat goes straight from the bus into the installed line.
        wr_line_s   = {bmem_rdata, fill_buf_r[2], fill_buf_r[1], fill_buf_r[0]};
        hit_s       = (state_r == COMPARE) && rd_valid_s && (rd_tag_s == req_tag_s);
        if (state_r == RESPOND) begin
            resp_s      = 1'b1;
            resp_word_s = icache_word(fill_line_s, req_addr_r[4:2]);
        end else begin
            resp_s      = hit_s;
            resp_word_s = icache_word(rd_line_s, req_addr_r[4:2]);
        end
        // Fetch only advances its address on a response, so a new request
        // is sampled only from IDLE or in a response cycle.
        capture_s   = (imem_rmask != 4'b0000) && ((state_r == IDLE) || resp_s);
        last_beat_s = (state_r == FILL_WAIT) && bmem_rvalid && (beat_cnt_r == 2'd3);
        wr_en_s     = last_beat_s && rst;
    end

    // Controller: request capture, state sequencing, refill address, rdata hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            beat_cnt_r  <= 2'd0;
            req_addr_r  <= 32'd0;
            bmem_addr_r <= 32'd0;
            rdata_r     <= 32'd0;
        end else begin
            if (capture_s) begin
                req_addr_r <= imem_addr;
            end
            if (resp_s) begin
                rdata_r <= resp_word_s;
            end
            case (state_r)
                IDLE: begin
                    if (capture_s) begin
                        state_r <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit_s) begin
                        state_r <= capture_s ? COMPARE : IDLE;
                    end else begin
                        state_r     <= FILL_REQ;
                        bmem_addr_r <= {req_addr_r[31:5], 5'b00000};
                    end
                end
                FILL_REQ: begin
                    if (bmem_ready) begin
                        state_r    <= FILL_WAIT;
                        beat_cnt_r <= 2'd0;
                    end
                end
                FILL_WAIT: begin
                    if (bmem_rvalid) begin
                        beat_cnt_r <= beat_cnt_r + 2'd1;
                        if (beat_cnt_r == 2'd3) begin
                            state_r <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    state_r <= capture_s ? COMPARE : IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Fill buffer: collects refill beats in arrival order.
    always_ff @(posedge clk) begin
        if ((state_r == FILL_WAIT) && bmem_rvalid) begin
            fill_buf_r[beat_cnt_r] <= bmem_rdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating hit/miss counters, sampled on each COMPARE decision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (hit_s && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state_r == COMPARE) && !hit_s && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

    assign imem_resp  = resp_s;
    assign imem_rdata = resp_s ? resp_word_s : rdata_r;
    assign bmem_read  = (state_r == FILL_REQ) && bmem_ready;
    assign bmem_addr  = bmem_addr_r;

    // Byte-offset bits and the start-PC parameter carry no logic.
    assign unused_s = ^{req_addr_r[1:0], INIT_PC};

endmodule

// File: tb/tb_icache_responder.sv
// Directed self-checking bench for icache_responder: reset, cold miss,
// streaming hits, conflict eviction, delayed bmem_ready, fetch flush during a
// refill and reset during a refill. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, before the next rising edge.
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_ready;
    logic        bmem_rvalid;
    logic [63:0] bmem_rdata;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] beat_q [4];

    always #5 clk = ~clk;

    icache_responder #(.SETS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_resp   (imem_resp),
        .imem_rdata  (imem_rdata),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_ready  (bmem_ready),
        .bmem_rvalid (bmem_rvalid),
        .bmem_rdata  (bmem_rdata)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line whose word w reads back as {p, 16'hw}.
    task automatic load_beats(input logic [15:0] p);
        for (int k = 0; k < 4; k++) begin
            beat_q[k] = {p, 16'(2 * k + 1), p, 16'(2 * k)};
        end
    endtask

    // Entered in the miss-detect cycle; returns sampled in the RESPOND cycle.
    task automatic serve_fill(input string tag, input logic [31:0] exp_addr, input int ready_delay);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            bmem_ready = 1'b0;
            #1;
            check({tag, "_read_held"}, bmem_read, 1'b0);
        end
        @(negedge clk);
        bmem_ready = 1'b1;
        #1;
        check({tag, "_read"}, bmem_read, 1'b1);
        check({tag, "_addr"}, bmem_addr, exp_addr);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bmem_rvalid = 1'b1;
            bmem_rdata  = beat_q[k];
            #1;
            check({tag, "_read_once"}, bmem_read, 1'b0);
            check({tag, "_no_early_resp"}, imem_resp, 1'b0);
        end
        @(negedge clk);
        bmem_rvalid = 1'b0;
        bmem_rdata  = 64'd0;
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        imem_addr   = 32'd0;
        imem_rmask  = 4'b0000;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_rdata  = 64'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp", imem_resp, 1'b0);
        check("rst_rdata", imem_rdata, 32'd0);
        check("rst_bmem_read", bmem_read, 1'b0);
        check("rst_bmem_addr", bmem_addr, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
`endif
        rst = 1'b1;

        // Cold miss on 0x60000000
        @(negedge clk);
        imem_addr  = 32'h6000_0000;
        imem_rmask = 4'b1111;
        #1;
        check("idle_no_resp", imem_resp, 1'b0);
        @(negedge clk);
        #1;
        check("cold_miss_no_resp", imem_resp, 1'b0);
        load_beats(16'h1111);
        serve_fill("cold", 32'h6000_0000, 0);
        check("cold_resp", imem_resp, 1'b1);
        check("cold_rdata", imem_rdata, 32'h1111_0000);

        // Sequential hits 0x04..0x1C, one per cycle
        imem_addr = 32'h6000_0004;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("seq_resp", imem_resp, 1'b1);
            check("seq_rdata", imem_rdata, {16'h1111, 16'(i)});
            if (i < 7) begin
                imem_addr = 32'h6000_0000 + 32'(4 * (i + 1));
            end else begin
                imem_rmask = 4'b0000;
            end
        end
        @(negedge clk);
        #1;
        check("seq_idle", imem_resp, 1'b0);
        check("rdata_hold", imem_rdata, 32'h1111_0007);

        // Conflict: 0x60000200 shares index 0
        imem_addr  = 32'h6000_0200;
        imem_rmask = 4'b1111;
        @(negedge clk);
        #1;
        check("conflict_miss", imem_resp, 1'b0);
        load_beats(16'h5555);
        serve_fill("conflict", 32'h6000_0200, 0);
        check("conflict_resp", imem_resp, 1'b1);
        check("conflict_rdata", imem_rdata, 32'h5555_0000);

        // Evicted line misses again; bmem_ready held low for 5 cycles
        imem_addr = 32'h6000_0000;
        @(negedge clk);
        #1;
        check("evicted_miss", imem_resp, 1'b0);
        load_beats(16'h7777);
        serve_fill("ready_delay", 32'h6000_0000, 5);
        check("evicted_resp", imem_resp, 1'b1);
        check("evicted_rdata", imem_rdata, 32'h7777_0000);
        imem_rmask = 4'b0000;
        @(negedge clk);
        #1;
        check("evicted_idle", imem_resp, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
        check("perf_hits", hit_count, 32'd7);
        check("perf_misses", miss_count, 32'd3);
`endif

        // Flush: rmask drops the cycle after capture, address moves on
        imem_addr  = 32'h6000_0020;
        imem_rmask = 4'b1111;
        @(negedge clk);
        imem_rmask = 4'b0000;
        imem_addr  = 32'h6000_0024;
        #1;
        check("flush_miss", imem_resp, 1'b0);
        load_beats(16'h9999);
        serve_fill("flush", 32'h6000_0020, 0);
        check("flush_resp", imem_resp, 1'b1);
        check("flush_rdata", imem_rdata, 32'h9999_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("flush_single_resp", imem_resp, 1'b0);
            check("flush_rdata_hold", imem_rdata, 32'h9999_0000);
        end

        // Reset during beat 2 of a refill, rmask of 4'b0101 counts as a request
        imem_addr  = 32'h6000_0040;
        imem_rmask = 4'b0101;
        @(negedge clk);
        #1;
        check("rmask_0101_miss", imem_resp, 1'b0);
        load_beats(16'hAAAA);
        @(negedge clk);
        bmem_ready = 1'b1;
        #1;
        check("midrst_read", bmem_read, 1'b1);
        check("midrst_addr", bmem_addr, 32'h6000_0040);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bmem_rvalid = 1'b1;
            bmem_rdata  = beat_q[k];
        end
        rst        = 1'b0;
        imem_rmask = 4'b0000;
        @(negedge clk);
        rst         = 1'b1;
        bmem_rdata  = beat_q[3];
        #1;
        check("midrst_resp", imem_resp, 1'b0);
        check("midrst_rdata", imem_rdata, 32'd0);
        check("midrst_bmem_read", bmem_read, 1'b0);
        check("midrst_bmem_addr", bmem_addr, 32'd0);
        @(negedge clk);
        bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        check("stray_beat_resp", imem_resp, 1'b0);
        @(negedge clk);
        bmem_rvalid = 1'b0;
        bmem_rdata  = 64'd0;
        #1;
        check("stray_idle_resp", imem_resp, 1'b0);
        check("stray_idle_rdata", imem_rdata, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        check("midrst_hits", hit_count, 32'd0);
        check("midrst_misses", miss_count, 32'd0);
`endif

        // Same line after the abandoned fill must miss
        imem_addr  = 32'h6000_0040;
        imem_rmask = 4'b1111;
        @(negedge clk);
        #1;
        check("after_rst_miss", imem_resp, 1'b0);
        load_beats(16'hBBBB);
        serve_fill("after_rst", 32'h6000_0040, 0);
        check("after_rst_resp", imem_resp, 1'b1);
        check("after_rst_rdata", imem_rdata, 32'hBBBB_0000);

        // Line filled before reset must also miss (valid bits cleared)
        imem_addr = 32'h6000_0008;
        @(negedge clk);
        #1;
        check("valid_cleared_miss", imem_resp, 1'b0);
        load_beats(16'hCCCC);
        serve_fill("valid_cleared", 32'h6000_0000, 0);
        check("valid_cleared_resp", imem_resp, 1'b1);
        check("valid_cleared_rdata", imem_rdata, 32'hCCCC_0002);
        imem_rmask = 4'b0000;
        @(negedge clk);
        #1;
        check("final_idle", imem_resp, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
